// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queues valid/ready commands and issues them as
// two-phase APB transfers, reporting each one on a response strobe.
module apb_cmd_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          push, pop, empty;

  state_t        state, state_n;
  logic [TW-1:0] wcnt;
  logic          done, last_wait;

  assign cmd_ready = (cnt != CW'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rp];
  assign busy      = (state != IDLE) || !empty;
  assign last_wait = (wcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (push)
      mem[wp] <= '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        // A timeout completes the transfer just like PREADY does.
        if (PREADY || last_wait) begin
          done = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wcnt      <= '0;
    end else begin
      PSEL      <= (state_n != IDLE);
      PENABLE   <= (state_n == ACCESS);
      rsp_valid <= done;
      rsp_write <= done && PWRITE;
      rsp_err   <= done && !PREADY;
      rsp_rdata <= (done && PREADY && !PWRITE) ? PRDATA : '0;
      if (pop) begin
        PWRITE <= head.wr;
        PADDR  <= head.addr;
        PWDATA <= head.wr ? head.wdata : '0;
        wcnt   <= '0;
      end else if (state == ACCESS && !PREADY) begin
        wcnt <= wcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_apb_cmd_master;

  localparam int TO = 16;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY = 1'b1;
  logic       rsp_valid, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic       busy;

  logic       echo = 1'b0;
  logic [7:0] prdata_r = '0;
  assign PRDATA = echo ? PADDR + 8'h40 : prdata_r;

  apb_cmd_master #(
    .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int passes = 0;
  int cyc = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  n, act, exp, $time);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
  } cmd_s;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       e;
    int         c;
  } rsp_s;

  // Model: queue of accepted-but-unissued commands plus the
  // transfer in flight and its age (0 = SETUP, n = n-th ACCESS).
  cmd_s pend[$];
  cmd_s cur;
  bit   act;
  int   age;
  bit   m_ok = 1'b0;
  logic e_psel, e_pen, e_pwrite, e_ready, e_busy;
  logic e_rv, e_rw, e_re;
  logic [7:0] e_paddr, e_pwdata, e_rd;

  initial forever begin
    bit   comp, acc;
    cmd_s nc;
    @(posedge PCLK);
    cyc++;
    if (PRESET) begin
      pend.delete();
      act = 0; age = 0; m_ok = 1;
      e_psel = 0; e_pen = 0; e_pwrite = 0;
      e_paddr = 0; e_pwdata = 0;
      e_rv = 0; e_rw = 0; e_re = 0; e_rd = 0;
      e_ready = 1; e_busy = 0;
    end else if (m_ok) begin
      comp = act && age >= 1 && (PREADY || age == TO);
      acc  = cmd_valid && (pend.size() < 4);
      e_rv = comp;
      e_rw = comp && cur.wr;
      e_re = comp && !PREADY;
      e_rd = (comp && PREADY && !cur.wr) ? PRDATA : 8'h00;
      if ((!act || comp) && pend.size() > 0) begin
        cur = pend.pop_front();
        act = 1; age = 0;
        e_pwrite = cur.wr;
        e_paddr  = cur.a;
        e_pwdata = cur.wr ? cur.d : 8'h00;
      end else if (comp) begin
        act = 0;
      end else if (act) begin
        age++;
      end
      if (acc) begin
        nc.wr = cmd_write; nc.a = cmd_addr; nc.d = cmd_wdata;
        pend.push_back(nc);
      end
      e_psel  = act;
      e_pen   = act && age >= 1;
      e_ready = pend.size() < 4;
      e_busy  = act || pend.size() > 0;
    end
  end

  initial forever begin
    @(negedge PCLK);
    if (m_ok) begin
      chk("PSEL", PSEL, e_psel);
      chk("PENABLE", PENABLE, e_pen);
      chk("PWRITE", PWRITE, e_pwrite);
      chk("PADDR", PADDR, e_paddr);
      chk("PWDATA", PWDATA, e_pwdata);
      chk("cmd_ready", cmd_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_write", rsp_write, e_rw);
      chk("rsp_err", rsp_err, e_re);
      chk("rsp_rdata", rsp_rdata, e_rd);
    end
  end

  rsp_s rlog[$];
  initial forever begin
    rsp_s r;
    @(negedge PCLK);
    if (rsp_valid === 1'b1) begin
      r.w = rsp_write; r.d = rsp_rdata; r.e = rsp_err; r.c = cyc;
      rlog.push_back(r);
    end
  end

  task automatic send(input logic w, input logic [7:0] a,
                      input logic [7:0] d,
                      output int waits, output int acyc);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 50) begin
      @(negedge PCLK);
      waits++;
    end
    if (waits >= 50) chk("accept_timeout", waits, 0);
    @(negedge PCLK);
    acyc = cyc;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    int b = 0;
    while (rlog.size() < n && b < 100) begin
      @(negedge PCLK);
      b++;
    end
    chk("rsp_count", rlog.size(), n);
  endtask

  initial begin
    int w, k;
    repeat (2) @(negedge PCLK);
    PRESET = 0;
    chk("rst_psel", PSEL, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", rsp_valid, 0);
    repeat (2) @(negedge PCLK);

    // single write, zero wait
    rlog.delete();
    send(1, 8'h01, 8'h09, w, k);
    chk("t1_idle_psel", PSEL, 0);
    @(negedge PCLK);
    chk("t1_setup_psel", PSEL, 1);
    chk("t1_setup_pen", PENABLE, 0);
    chk("t1_paddr", PADDR, 8'h01);
    chk("t1_pwdata", PWDATA, 8'h09);
    @(negedge PCLK);
    chk("t1_acc_pen", PENABLE, 1);
    @(negedge PCLK);
    chk("t1_done_psel", PSEL, 0);
    chk("t1_rv", rsp_valid, 1);
    chk("t1_rw", rsp_write, 1);
    chk("t1_re", rsp_err, 0);
    wait_rsp(1);
    if (rlog.size() > 0) chk("t1_lat", rlog[0].c - k, 3);
    repeat (2) @(negedge PCLK);

    // read with two wait states
    rlog.delete();
    PREADY = 0; prdata_r = 8'h5A;
    send(0, 8'h02, 8'hFF, w, k);
    @(negedge PCLK);
    chk("t2_pwdata", PWDATA, 8'h00);
    @(negedge PCLK);
    chk("t2_acc1", PENABLE, 1);
    @(negedge PCLK);
    chk("t2_acc2", PENABLE, 1);
    chk("t2_paddr2", PADDR, 8'h02);
    @(negedge PCLK);
    chk("t2_acc3", PENABLE, 1);
    chk("t2_paddr3", PADDR, 8'h02);
    PREADY = 1;
    wait_rsp(1);
    if (rlog.size() > 0) begin
      chk("t2_rdata", rlog[0].d, 8'h5A);
      chk("t2_err", rlog[0].e, 0);
      chk("t2_lat", rlog[0].c - k, 5);
    end
    repeat (2) @(negedge PCLK);

    // burst of five while the first transfer stalls
    rlog.delete();
    echo = 1; PREADY = 0;
    for (int i = 0; i < 5; i++)
      send(i % 2 == 0, 8'h10 + 8'(i), 8'hA0 + 8'(i), w, k);
    chk("t3_full", cmd_ready, 0);
    PREADY = 1;
    wait_rsp(5);
    for (int i = 0; i < rlog.size(); i++) begin
      chk("t3_w", rlog[i].w, (i % 2 == 0));
      chk("t3_d", rlog[i].d,
          (i % 2 == 0) ? 8'h00 : 8'h50 + 8'(i));
    end
    if (rlog.size() == 5) chk("t3_span", rlog[4].c - rlog[0].c, 8);
    repeat (2) @(negedge PCLK);

    // timeout on a read
    rlog.delete();
    echo = 0; prdata_r = 8'hA5; PREADY = 0;
    send(0, 8'h03, 8'h00, w, k);
    wait_rsp(1);
    if (rlog.size() > 0) begin
      chk("t4_lat", rlog[0].c - k, 18);
      chk("t4_err", rlog[0].e, 1);
      chk("t4_rdata", rlog[0].d, 8'h00);
    end
    @(negedge PCLK);
    chk("t4_idle", PSEL, 0);
    chk("t4_busy", busy, 0);
    PREADY = 1;
    repeat (2) @(negedge PCLK);

    // reset mid-ACCESS with two queued
    PREADY = 0;
    for (int i = 0; i < 3; i++)
      send(1, 8'h30 + 8'(i), 8'h11, w, k);
    chk("t5_pen", PENABLE, 1);
    PRESET = 1;
    @(negedge PCLK);
    rlog.delete();
    chk("t5_psel", PSEL, 0);
    chk("t5_penable", PENABLE, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_busy", busy, 0);
    PRESET = 0; PREADY = 1;
    repeat (30) @(negedge PCLK);
    chk("t5_no_rsp", rlog.size(), 0);

    // full FIFO, new command offered on the completion edge
    rlog.delete();
    echo = 1; PREADY = 0;
    for (int i = 0; i < 5; i++)
      send(0, 8'h20 + 8'(i), 8'h00, w, k);
    chk("t6_full", cmd_ready, 0);
    PREADY = 1;
    send(0, 8'h25, 8'h00, w, k);
    chk("t6_wait", w, 1);
    wait_rsp(6);
    for (int i = 0; i < rlog.size(); i++)
      chk("t6_d", rlog[i].d, 8'h60 + 8'(i));
    repeat (4) @(negedge PCLK);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
